// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I load/store unit in front of an internal word-organised synchronous RAM.
// Optional build macro DMEM_MISALIGN_FAULT_EN: misaligned H/HU/W accesses fault instead of being aligned.
module dmem_lsu #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic          phase;
    logic          cap_we;
    logic [2:0]    cap_funct3;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [AW+1:0] eff_addr;
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          fault;
    logic          misalign;
    logic          range_bad;
    logic          funct3_bad;
    logic          mem_we;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [31:0]   ram_q;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_data;
    logic [31:0]   mem [DEPTH_WORDS];

    // Handshake: a request transfers on a rising edge where req_valid and req_ready are both
    // high; req_ready is high only in IDLE, so at most one request is in flight.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    assign funct3_bad = (cap_funct3 == 3'b011) || (cap_funct3 == 3'b110) ||
                        (cap_funct3 == 3'b111) || (cap_we && cap_funct3[2]);
    assign range_bad  = |cap_addr[31:AW+2];

`ifdef DMEM_MISALIGN_FAULT_EN
    assign misalign = ((cap_funct3[1:0] == 2'b01) && cap_addr[0]) ||
                      ((cap_funct3[1:0] == 2'b10) && (cap_addr[1:0] != 2'b00));
    assign eff_addr = cap_addr[AW+1:0];
`else
    assign misalign = 1'b0;
    // Halfword and word accesses silently drop the low address bits.
    always_comb begin
        eff_addr = cap_addr[AW+1:0];
        if (cap_funct3[1:0] == 2'b01) begin
            eff_addr[0] = 1'b0;
        end else if (cap_funct3[1:0] == 2'b10) begin
            eff_addr[1:0] = 2'b00;
        end
    end
`endif

    assign fault    = funct3_bad || range_bad || misalign;
    assign word_idx = eff_addr[AW+1:2];
    assign lane     = eff_addr[1:0];

    // ACCESS takes two cycles on the normal path: phase 0 reads the RAM, phase 1 writes/formats.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = ACCESS;
            ACCESS:  if (fault || phase) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= 1'b0;
            cap_we     <= 1'b0;
            cap_funct3 <= 3'b000;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            rsp_rdata  <= '0;
            rsp_fault  <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= (state == ACCESS) && !phase && !fault;
            if (req_valid && req_ready) begin
                cap_we     <= req_we;
                cap_funct3 <= req_funct3;
                cap_addr   <= req_addr;
                cap_wdata  <= req_wdata;
            end
            if (state == ACCESS && state_nxt == RESP) begin
                rsp_fault <= fault;
                rsp_rdata <= (fault || cap_we) ? 32'd0 : load_data;
            end else begin
                rsp_fault <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

    always_comb begin
        wr_be   = 4'b1111;
        wr_data = cap_wdata;
        case (cap_funct3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{cap_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign mem_we = (state == ACCESS) && phase && cap_we;

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        if (state == ACCESS && !phase) ram_q <= mem[word_idx];
    end

    always_comb begin
        case (lane)
            2'd0:    byte_v = ram_q[7:0];
            2'd1:    byte_v = ram_q[15:8];
            2'd2:    byte_v = ram_q[23:16];
            default: byte_v = ram_q[31:24];
        endcase
        half_v = lane[1] ? ram_q[31:16] : ram_q[15:0];
        case (cap_funct3)
            3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_data = {24'd0, byte_v};
            3'b001:  load_data = {{16{half_v[15]}}, half_v};
            3'b101:  load_data = {16'd0, half_v};
            default: load_data = ram_q;
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized scoreboard bench for dmem_lsu against a byte-array reference model.
// Honours DMEM_MISALIGN_FAULT_EN the same way as the design build.
module tb_dmem_lsu;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic        fault;
        logic [31:0] due;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        busy;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    logic [7:0]  mem_m [4*DEPTH];

    dmem_lsu #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .busy(busy)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: little-endian byte array, RV32I access rules.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic fault,
                                  output logic [31:0] rdata);
        int unsigned size;
        int unsigned a;
        logic [31:0] v;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        fault = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) ||
                ((addr >> 2) >= DEPTH);
`ifdef DMEM_MISALIGN_FAULT_EN
        if ((addr % size) != 0) fault = 1'b1;
        a = addr;
`else
        a = addr - (addr % size);
`endif
        rdata = 32'd0;
        if (!fault) begin
            if (we) begin
                for (int i = 0; i < int'(size); i++) mem_m[a+i] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < int'(size); i++) v = v | (32'(mem_m[a+i]) << (8*i));
                if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
                rdata = v;
            end
        end
    endfunction

    // driver: one request, expected response pushed at the handshake
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        exp_t        e;
        logic        f;
        logic [31:0] r;
        int          guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (!req_ready) begin
            n_fail++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 within 20 cycles");
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        model(we, f3, addr, wdata, f, r);
        e.fault = f;
        e.rdata = r;
        e.due   = cyc + (f ? 32'd2 : 32'd3);
        exp_q.push_back(e);
        @(negedge clk);
        // garbage with valid held high while busy must be ignored
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("ready_vs_busy", 32'(req_ready), 32'(!busy));
            if (rsp_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response pending");
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_fault", 32'(rsp_fault), 32'(e.fault));
                    chk("rsp_latency", cyc, e.due);
                end
            end else begin
                chk("idle_rdata_zero", rsp_rdata, 32'd0);
                chk("idle_fault_zero", 32'(rsp_fault), 32'd0);
            end
        end
    end

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [2:0] f3_tab [5];
        logic [2:0] f3;
        logic [31:0] addr;
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        for (int w = 0; w < DEPTH; w++) issue(1'b1, 3'b010, 32'(w * 4), $urandom);

        // directed
        issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h10, 32'd0);
        issue(1'b1, 3'b000, 32'h13, 32'h0000_0080);
        issue(1'b0, 3'b000, 32'h13, 32'd0);
        issue(1'b0, 3'b100, 32'h13, 32'd0);
        issue(1'b0, 3'b010, 32'h10, 32'd0);
        issue(1'b1, 3'b001, 32'h22, 32'h0000_8001);
        issue(1'b0, 3'b001, 32'h22, 32'd0);
        issue(1'b0, 3'b101, 32'h22, 32'd0);
        issue(1'b0, 3'b001, 32'h20, 32'd0);
        issue(1'b0, 3'b010, 32'h12, 32'd0);
        issue(1'b1, 3'b001, 32'h11, 32'h0000_5A5A);
        issue(1'b0, 3'b010, 32'h10, 32'd0);
        issue(1'b0, 3'b010, 32'(4 * DEPTH), 32'd0);
        issue(1'b0, 3'b011, 32'h10, 32'd0);
        issue(1'b1, 3'b101, 32'h20, 32'h0000_1234);
        issue(1'b0, 3'b010, 32'h20, 32'd0);
        issue(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h1111_2222);
        issue(1'b0, 3'b010, 32'(4 * DEPTH - 4), 32'd0);
        drain();

        // reset during ACCESS drops the store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h14; req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
        chk("midrst_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        issue(1'b0, 3'b010, 32'h14, 32'd0);

        // random
        for (int n = 0; n < 400; n++) begin
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : f3_tab[$urandom_range(0, 4)];
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
            issue(1'($urandom_range(0, 1)), f3, addr, $urandom);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
